// File: rtl/hilo_mult_ctrl_pkg.sv
// Shared HI/LO definitions: op_code encodings, sequencer states, watchdog default.
// Optional accumulate ops are enabled elsewhere with the HILO_MADD_EN macro.
package hilo_mult_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MTHI  = 3'd3,
        OP_MTLO  = 3'd4,
        OP_MADD  = 3'd5,
        OP_MADDU = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam int MAX_CYCLES_DEF = 40;

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Execute-stage <-> HI/LO sequencer bus: op issue, MFHI/MFLO request, stall and HI/LO readback.
interface hilo_mult_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mf_req;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;

    modport master (
        output op_valid, op_code, op_a, op_b, mf_req,
        input  stall, busy, hi, lo, err
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, mf_req,
        output stall, busy, hi, lo, err
    );
endinterface

// File: rtl/hilo_mult_ctrl_acc.sv
// 64-bit HI/LO register: undoes the multiplier's unsigned sign flip, optional accumulate
// (HILO_MADD_EN), and MTHI/MTLO write ports.
module hilo_mult_ctrl_acc (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic        acc_en,
    input  logic        neg_fix,
    input  logic [63:0] mul_s,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] product;
    logic [63:0] result;

    assign product = neg_fix ? (~mul_s + 64'd1) : mul_s;

`ifdef HILO_MADD_EN
    assign result = acc_en ? ({hi, lo} + product) : product;
`else
    logic unused_acc_en;
    assign unused_acc_en = acc_en;
    assign result        = product;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            {hi, lo} <= result;
        end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Iterative-multiplier sequencer and HI/LO owner. MADD/MADDU exist only when HILO_MADD_EN
// is defined; otherwise they pulse err like the reserved op.
module hilo_mult_ctrl
    import hilo_mult_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    hilo_mult_ctrl_if.slave ex,
    output logic [31:0]     mul_a,
    output logic [31:0]     mul_b,
    output logic            mul_start,
    output logic            mul_signed,
    input  logic            mul_ready,
    input  logic [63:0]     mul_s
);

    localparam int              WDW      = $clog2(MAX_CYCLES);
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(MAX_CYCLES - 1);

    state_e         state, state_nx;
    logic [WDW-1:0] wdog;
    logic           first_wait;
    logic           acc_op;
    logic           err_q;
    logic           is_mul, is_illegal;
    logic           idle_op, start_op, illegal_op;
    logic           commit, abort;

    always_comb begin
        is_mul     = 1'b0;
        is_illegal = 1'b0;
        case (ex.op_code)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef HILO_MADD_EN
            OP_MADD, OP_MADDU: is_mul = 1'b1;
`else
            OP_MADD, OP_MADDU: is_illegal = 1'b1;
`endif
            OP_RSVD:           is_illegal = 1'b1;
            default:           ;
        endcase
    end

    assign idle_op    = ex.op_valid && (state == S_IDLE);
    assign start_op   = idle_op && is_mul;
    assign illegal_op = idle_op && is_illegal;

    // A ready seen in the first WAIT cycle is the stale idle level, not a result.
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state)
            S_IDLE:  if (start_op) state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                if (mul_ready && !first_wait) begin
                    commit   = 1'b1;
                    state_nx = S_IDLE;
                end else if (wdog == WD_LIMIT) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            acc_op     <= 1'b0;
            wdog       <= '0;
            first_wait <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            first_wait <= (state == S_START);
            err_q      <= abort || illegal_op;
            if (start_op) begin
                mul_a      <= ex.op_a;
                mul_b      <= ex.op_b;
                mul_signed <= (ex.op_code == OP_MULT) || (ex.op_code == OP_MADD);
                acc_op     <= (ex.op_code == OP_MADD) || (ex.op_code == OP_MADDU);
            end
            if (state == S_START)     wdog <= '0;
            else if (state == S_WAIT) wdog <= wdog + WDW'(1);
        end
    end

    assign mul_start = (state == S_START);
    assign ex.busy   = (state != S_IDLE);
    assign ex.stall  = ex.busy && (ex.op_valid || ex.mf_req);
    assign ex.err    = err_q;

    // Operands are held until IDLE, so the unsigned fix can use them at commit.
    hilo_mult_ctrl_acc u_acc (
        .clk     (clk),
        .reset   (reset),
        .wr_hi   (idle_op && (ex.op_code == OP_MTHI)),
        .wr_lo   (idle_op && (ex.op_code == OP_MTLO)),
        .wr_data (ex.op_a),
        .commit  (commit),
        .acc_en  (acc_op),
        .neg_fix (!mul_signed && (mul_a[31] ^ mul_b[31])),
        .mul_s   (mul_s),
        .hi      (ex.hi),
        .lo      (ex.lo)
    );

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a 32-cycle iterative multiplier stand-in.
module tb_hilo_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mul_a, mul_b;
    logic        mul_start, mul_signed;
    logic        mul_ready;
    logic [63:0] mul_s;
    logic        stuck;
    logic        running;
    int          cnt;
    int          total = 0;
    int          bad   = 0;

    hilo_mult_ctrl_if ex ();

    hilo_mult_ctrl #(.MAX_CYCLES(40)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex         (ex),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_signed (mul_signed),
        .mul_ready  (mul_ready),
        .mul_s      (mul_s)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: in unsigned mode it still flips the sign on a[31]^b[31].
    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [63:0] p;
        if (s) begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        end else begin
            p = {32'd0, a} * {32'd0, b};
            if (a[31] ^ b[31]) p = ~p + 64'd1;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mul_ready <= 1'b1;
            running   <= 1'b0;
            cnt       <= 0;
            mul_s     <= '0;
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            running   <= 1'b1;
            cnt       <= 0;
        end else if (running && !stuck) begin
            if (cnt == 31) begin
                mul_ready <= 1'b1;
                running   <= 1'b0;
                mul_s     <= mul_model(mul_a, mul_b, mul_signed);
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Issue at cycle 0, then observe from cycle 1 until busy drops (bounded).
    task automatic do_mul(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int start_cyc, output logic e);
        ex.op_valid = 1'b1; ex.op_code = code; ex.op_a = a; ex.op_b = b;
        @(negedge clk);
        ex.op_valid = 1'b0; ex.op_code = 3'd0;
        nbusy = 0; start_cyc = -1; e = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (mul_start && start_cyc < 0) start_cyc = c;
            if (ex.err) e = 1'b1;
            if (!ex.busy) break;
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        ex.op_valid = 1'b1; ex.op_code = 3'd3; ex.op_a = h;
        @(negedge clk);
        ex.op_code = 3'd4; ex.op_a = l;
        @(negedge clk);
        ex.op_valid = 1'b0; ex.op_code = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ex.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ex.busy); end
        total++; if ({ex.hi, ex.lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {ex.hi, ex.lo}); end
        total++; if ({mul_start, mul_signed, ex.err, ex.stall} !== 4'b0) begin bad++; $display("FAIL reset_ctl: got %b want 0000", {mul_start, mul_signed, ex.err, ex.stall}); end
        total++; if ({mul_a, mul_b} !== 64'd0) begin bad++; $display("FAIL reset_ops: got %h want 0", {mul_a, mul_b}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int nb, sc; logic e;
        do_mul(3'd1, 32'hFFFFFFFD, 32'd5, nb, sc, e);
        total++; if (nb !== 34) begin bad++; $display("FAIL mult_busy: got %0d want 34", nb); end
        total++; if (sc !== 1) begin bad++; $display("FAIL mult_start: got %0d want 1", sc); end
        total++; if ({ex.hi, ex.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin bad++; $display("FAIL mult_hilo: got %h want FFFFFFFFFFFFFFF1", {ex.hi, ex.lo}); end
        do_mul(3'd1, 32'h80000000, 32'h80000000, nb, sc, e);
        total++; if ({ex.hi, ex.lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_minmin: got %h want 4000000000000000", {ex.hi, ex.lo}); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL mult_err: got %b want 0", e); end
    endtask

    task automatic test_multu();
        int nb, sc; logic e;
        do_mul(3'd2, 32'hFFFFFFFF, 32'd2, nb, sc, e);
        total++; if ({ex.hi, ex.lo} !== 64'h00000001_FFFFFFFE) begin bad++; $display("FAIL multu_fix: got %h want 00000001FFFFFFFE", {ex.hi, ex.lo}); end
        total++; if (nb !== 34) begin bad++; $display("FAIL multu_busy: got %0d want 34", nb); end
        do_mul(3'd2, 32'h00010000, 32'h00010000, nb, sc, e);
        total++; if ({ex.hi, ex.lo} !== 64'h00000001_00000000) begin bad++; $display("FAIL multu_plain: got %h want 0000000100000000", {ex.hi, ex.lo}); end
    endtask

    task automatic test_mthi_mtlo();
        ex.op_valid = 1'b1; ex.op_code = 3'd3; ex.op_a = 32'h12345678;
        @(negedge clk);
        total++; if (ex.hi !== 32'h12345678) begin bad++; $display("FAIL mthi: got %h want 12345678", ex.hi); end
        ex.op_code = 3'd4; ex.op_a = 32'h9ABCDEF0;
        total++; if ({ex.busy, ex.stall} !== 2'b00) begin bad++; $display("FAIL mthi_busy: got %b want 00", {ex.busy, ex.stall}); end
        @(negedge clk);
        ex.op_valid = 1'b0; ex.op_code = 3'd0;
        total++; if ({ex.hi, ex.lo} !== 64'h12345678_9ABCDEF0) begin bad++; $display("FAIL mtlo: got %h want 123456789ABCDEF0", {ex.hi, ex.lo}); end
        total++; if ({ex.busy, ex.stall} !== 2'b00) begin bad++; $display("FAIL mtlo_busy: got %b want 00", {ex.busy, ex.stall}); end
    endtask

    task automatic test_back_to_back();
        int n = 0, sbad = 0, nb, sc; logic e;
        ex.op_valid = 1'b1; ex.op_code = 3'd1; ex.op_a = 32'd7; ex.op_b = 32'd6;
        @(negedge clk);
        ex.op_a = 32'd3; ex.op_b = 32'd4; ex.mf_req = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            #1;
            if (!ex.busy) break;
            n++;
            if (ex.stall !== 1'b1) sbad++;
            @(negedge clk);
        end
        total++; if (n !== 34 || sbad !== 0) begin bad++; $display("FAIL b2b_stall: got busy=%0d stall_miss=%0d want 34/0", n, sbad); end
        total++; if (ex.stall !== 1'b0) begin bad++; $display("FAIL b2b_idle_stall: got %b want 0", ex.stall); end
        total++; if ({ex.hi, ex.lo} !== 64'd42) begin bad++; $display("FAIL b2b_first: got %h want 2a", {ex.hi, ex.lo}); end
        @(negedge clk);
        total++; if ({mul_start, ex.busy, mul_a} !== {2'b11, 32'd3}) begin bad++; $display("FAIL b2b_second_start: got %b/%b/%h want 1/1/3", mul_start, ex.busy, mul_a); end
        ex.op_valid = 1'b0; ex.op_code = 3'd0; ex.mf_req = 1'b0;
        nb = 0; sc = 0; e = 1'b0;
        for (int c = 0; c <= 80 && ex.busy; c++) @(negedge clk);
        total++; if ({ex.hi, ex.lo} !== 64'd12 || ex.busy !== 1'b0) begin bad++; $display("FAIL b2b_second: got %h busy=%b want c/0", {ex.hi, ex.lo}, ex.busy); end
        if (nb != 0 || sc != 0 || e) $display("note: unused locals");
    endtask

    task automatic test_reset_mid();
        int nb, sc; logic e;
        ex.op_valid = 1'b1; ex.op_code = 3'd1; ex.op_a = 32'h1234; ex.op_b = 32'h10;
        @(negedge clk);
        ex.op_valid = 1'b0; ex.op_code = 3'd0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({ex.busy, mul_start} !== 2'b00) begin bad++; $display("FAIL rstmid_ctl: got %b want 00", {ex.busy, mul_start}); end
        total++; if ({ex.hi, ex.lo} !== 64'd0) begin bad++; $display("FAIL rstmid_hilo: got %h want 0", {ex.hi, ex.lo}); end
        reset = 1'b0;
        @(negedge clk);
        do_mul(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, sc, e);
        total++; if ({ex.hi, ex.lo} !== 64'd1 || nb !== 34) begin bad++; $display("FAIL rstmid_after: got %h busy=%0d want 1/34", {ex.hi, ex.lo}, nb); end
    endtask

    task automatic test_watchdog();
        int nb, sc; logic e;
        write_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
        stuck = 1'b1;
        do_mul(3'd1, 32'd3, 32'd3, nb, sc, e);
        total++; if (e !== 1'b1 || nb !== 41) begin bad++; $display("FAIL wdog_abort: got err=%b busy=%0d want 1/41", e, nb); end
        total++; if ({ex.hi, ex.lo} !== 64'hA5A5A5A5_5A5A5A5A) begin bad++; $display("FAIL wdog_hilo: got %h want A5A5A5A55A5A5A5A", {ex.hi, ex.lo}); end
        @(negedge clk);
        total++; if (ex.err !== 1'b0) begin bad++; $display("FAIL wdog_pulse: got %b want 0", ex.err); end
        stuck = 1'b0;
    endtask

    task automatic test_illegal();
        int nb, sc; logic e;
        do_mul(3'd7, 32'd1, 32'd1, nb, sc, e);
        total++; if (e !== 1'b1 || nb !== 0) begin bad++; $display("FAIL rsvd: got err=%b busy=%0d want 1/0", e, nb); end
        total++; if ({ex.hi, ex.lo} !== 64'hA5A5A5A5_5A5A5A5A) begin bad++; $display("FAIL rsvd_hilo: got %h want A5A5A5A55A5A5A5A", {ex.hi, ex.lo}); end
    endtask

    task automatic test_madd();
        int nb, sc; logic e;
        write_hilo(32'd0, 32'hFFFFFFFF);
        do_mul(3'd6, 32'd1, 32'd1, nb, sc, e);
`ifdef HILO_MADD_EN
        total++; if ({ex.hi, ex.lo} !== 64'h00000001_00000000) begin bad++; $display("FAIL maddu: got %h want 0000000100000000", {ex.hi, ex.lo}); end
        total++; if (e !== 1'b0 || nb !== 34) begin bad++; $display("FAIL maddu_ctl: got err=%b busy=%0d want 0/34", e, nb); end
`else
        total++; if ({ex.hi, ex.lo} !== 64'h00000000_FFFFFFFF) begin bad++; $display("FAIL maddu_off: got %h want 00000000FFFFFFFF", {ex.hi, ex.lo}); end
        total++; if (e !== 1'b1 || nb !== 0) begin bad++; $display("FAIL maddu_off_ctl: got err=%b busy=%0d want 1/0", e, nb); end
`endif
        @(negedge clk);
        total++; if (ex.err !== 1'b0) begin bad++; $display("FAIL maddu_pulse: got %b want 0", ex.err); end
    endtask

    initial begin
        reset = 1'b1; stuck = 1'b0;
        ex.op_valid = 1'b0; ex.op_code = 3'd0; ex.op_a = '0; ex.op_b = '0; ex.mf_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_multu();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid();
        test_watchdog();
        test_illegal();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
